// File: rtl/fir_mac_mc.sv
// Multi-channel sequential FIR: one shared MAC walks the taps one per cycle,
// then rounds, saturates and hands the result out on a valid/ready port.
module fir_mac_mc #(
    parameter int NUM_TAPS    = 8,
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS),
    parameter int OUT_SHIFT   = 0,
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TAW        = $clog2(NUM_TAPS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHW-1:0]                in_ch,
    input  logic signed [DATA_WIDTH-1:0]  x_in,
    input  logic                          coef_we,
    input  logic [TAW-1:0]                coef_addr,
    input  logic signed [COEFF_WIDTH-1:0] coef_data,
    output logic                          coef_ready,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHW-1:0]                out_ch,
    output logic signed [DATA_WIDTH-1:0]  y_out,
    output logic                          sat,
    output logic                          ch_err
);

    typedef enum logic [2:0] {IDLE, SHIFT, LOOP_MAC, ROUND, DELIVER} state_t;

    localparam logic [TAW-1:0] LAST_TAP = TAW'(NUM_TAPS - 1);
    localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_WIDTH:0] RND =
        (OUT_SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RND_POS) : '0;
    localparam logic signed [ACC_WIDTH:0] MAX_Y = (ACC_WIDTH+1)'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] MIN_Y = ~MAX_Y;

    state_t state, state_next;

    logic signed [COEFF_WIDTH-1:0] coef [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]  line [NUM_CH][NUM_TAPS];
    logic signed [DATA_WIDTH-1:0]  x_lat;
    logic [CHW-1:0]                ch_lat;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [TAW-1:0]                cnt;

    logic                                     ch_ok;
    logic                                     bad_ch;
    logic signed [DATA_WIDTH+COEFF_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH:0]                acc_rnd;
    logic signed [ACC_WIDTH:0]                r;
    logic signed [DATA_WIDTH-1:0]             y_next;
    logic                                     sat_next;

    assign in_ready   = (state == IDLE);
    assign coef_ready = (state == IDLE);
    assign ch_ok      = (int'(in_ch) < NUM_CH);
    assign bad_ch     = in_valid && !ch_ok;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (in_valid && ch_ok) state_next = SHIFT;
            SHIFT:    state_next = LOOP_MAC;
            LOOP_MAC: if (cnt == LAST_TAP) state_next = ROUND;
            ROUND:    state_next = DELIVER;
            DELIVER:  if (out_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Round half toward +inf, then clip; one spare bit keeps the rounding add exact.
    always_comb begin
        prod     = coef[cnt] * line[ch_lat][cnt];
        acc_rnd  = (ACC_WIDTH+1)'(acc) + RND;
        r        = acc_rnd >>> OUT_SHIFT;
        sat_next = 1'b0;
        y_next   = r[DATA_WIDTH-1:0];
        if (r > MAX_Y) begin
            sat_next = 1'b1;
            y_next   = MAX_Y[DATA_WIDTH-1:0];
        end else if (r < MIN_Y) begin
            sat_next = 1'b1;
            y_next   = MIN_Y[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) coef[k] <= '0;
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < NUM_TAPS; k++) line[c][k] <= '0;
            x_lat     <= '0;
            ch_lat    <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            y_out     <= '0;
            out_ch    <= '0;
            sat       <= 1'b0;
            ch_err    <= 1'b0;
        end else begin
            ch_err <= 1'b0;
            case (state)
                IDLE: begin
                    // A rejected channel index leaves every piece of state alone.
                    if (bad_ch) begin
                        ch_err <= 1'b1;
                    end else begin
                        if (coef_we) coef[coef_addr] <= coef_data;
                        if (flush)
                            for (int c = 0; c < NUM_CH; c++)
                                for (int k = 0; k < NUM_TAPS; k++) line[c][k] <= '0;
                        if (in_valid) begin
                            x_lat  <= x_in;
                            ch_lat <= in_ch;
                        end
                    end
                end
                SHIFT: begin
                    for (int k = NUM_TAPS - 1; k > 0; k--)
                        line[ch_lat][k] <= line[ch_lat][k-1];
                    line[ch_lat][0] <= x_lat;
                    acc <= '0;
                    cnt <= '0;
                end
                LOOP_MAC: begin
                    acc <= acc + ACC_WIDTH'(prod);
                    cnt <= cnt + TAW'(1);
                end
                ROUND: begin
                    y_out     <= y_next;
                    sat       <= sat_next;
                    out_ch    <= ch_lat;
                    out_valid <= 1'b1;
                end
                DELIVER: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_mc.sv
// Directed bench for fir_mac_mc: a 2-channel OUT_SHIFT=0 instance carries most
// vectors, a 3-channel OUT_SHIFT=2 instance covers rounding and channel errors.
module tb_fir_mac_mc;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset, in_valid, in_valid2, coef_we, flush, out_ready;
    logic [0:0]        in_ch;
    logic [1:0]        in_ch2;
    logic signed [7:0] x_in;
    logic [1:0]        coef_addr;
    logic signed [7:0] coef_data;

    logic              in_ready, coef_ready, out_valid, sat, ch_err;
    logic [0:0]        out_ch;
    logic signed [7:0] y_out;
    logic              in_ready2, coef_ready2, out_valid2, sat2, ch_err2;
    logic [1:0]        out_ch2;
    logic signed [7:0] y_out2;

    fir_mac_mc #(.NUM_TAPS(4), .NUM_CH(2), .DATA_WIDTH(8), .COEFF_WIDTH(8), .OUT_SHIFT(0)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .x_in(x_in), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_ready(coef_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .y_out(y_out), .sat(sat), .ch_err(ch_err)
    );

    fir_mac_mc #(.NUM_TAPS(4), .NUM_CH(3), .DATA_WIDTH(8), .COEFF_WIDTH(8), .OUT_SHIFT(2)) dut2 (
        .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_ch(in_ch2), .x_in(x_in), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_ready(coef_ready2), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ch(out_ch2),
        .y_out(y_out2), .sat(sat2), .ch_err(ch_err2)
    );

    typedef struct {
        bit new_h;
        int h0, h1, h2, h3;
        bit fl;
        int ch, x;
        int ey, ech, esat;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic void add(input bit nh, input int a, b, c, d,
                                input bit fl, input int ch, x, ey, ech, esat);
        vec_t v;
        v.new_h = nh; v.h0 = a; v.h1 = b; v.h2 = c; v.h3 = d;
        v.fl = fl; v.ch = ch; v.x = x; v.ey = ey; v.ech = ech; v.esat = esat;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic load_h(input int a, b, c, d);
        int hv[4];
        hv[0] = a; hv[1] = b; hv[2] = c; hv[3] = d;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            coef_we   = 1'b1;
            coef_addr = 2'(k);
            coef_data = 8'(hv[k]);
        end
        @(negedge clock);
        coef_we = 1'b0;
    endtask

    task automatic apply_stimulus(input int ch, x, input bit fl);
        @(negedge clock);
        check_output("in_ready_before_send", in_ready, 1);
        in_valid  = 1'b1;
        in_valid2 = 1'b1;
        in_ch     = 1'(ch);
        in_ch2    = 2'(ch);
        x_in      = 8'(x);
        flush     = fl;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_one(input int ch, x, input bit fl, input string tag,
                           output int y, yc, s, y2, s2);
        int lat;
        apply_stimulus(ch, x, fl);
        wait_valid(lat);
        check_output({tag, "_latency"}, lat, 6);
        y = y_out; yc = out_ch; s = sat; y2 = y_out2; s2 = sat2;
        @(posedge clock);
        #1;
        check_output({tag, "_release"}, out_valid, 0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int y, yc, s, y2, s2, lat, seen;

        reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; coef_we = 1'b0; flush = 1'b0;
        out_ready = 1'b1; in_ch = '0; in_ch2 = '0; x_in = '0; coef_addr = '0; coef_data = '0;

        add(1, 1, 2, 3, 4, 1, 0, 10, 10, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 20, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 30, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 40, 0, 0);
        add(1, 1, 2, 3, 4, 1, 0, 10, 10, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 5, 5, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 20, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 10, 1, 0);
        add(1, 127, 127, 127, 127, 1, 0, 127, 127, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 127, 127, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 127, 127, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 127, 127, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, -128, -128, 0, 1);
        add(1, -2, 3, 0, 1, 1, 1, -20, 40, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 7, -74, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 21, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0, 127, 127, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, -128, -128, 0, 0);

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_y_out", y_out, 0);
        check_output("reset_out_ch", out_ch, 0);
        check_output("reset_sat", sat, 0);
        check_output("reset_ch_err", ch_err, 0);
        check_output("reset_in_ready", in_ready, 1);
        check_output("reset_coef_ready", coef_ready, 1);

        foreach (vecs[i]) begin
            if (vecs[i].new_h) load_h(vecs[i].h0, vecs[i].h1, vecs[i].h2, vecs[i].h3);
            run_one(vecs[i].ch, vecs[i].x, vecs[i].fl, $sformatf("v%0d", i), y, yc, s, y2, s2);
            check_output($sformatf("v%0d_y", i), y, vecs[i].ey);
            check_output($sformatf("v%0d_ch", i), yc, vecs[i].ech);
            check_output($sformatf("v%0d_sat", i), s, vecs[i].esat);
        end

        // Rounding on the OUT_SHIFT=2 instance with h = {1,0,0,0} still loaded.
        run_one(0, 6, 1, "rnd6", y, yc, s, y2, s2);
        check_output("rnd6_y", y2, 2);
        check_output("rnd6_sat", s2, 0);
        run_one(0, -6, 1, "rndm6", y, yc, s, y2, s2);
        check_output("rndm6_y", y2, -1);
        check_output("rndm6_sat", s2, 0);
        run_one(0, 5, 1, "rnd5", y, yc, s, y2, s2);
        check_output("rnd5_y", y2, 1);
        check_output("rnd5_sat", s2, 0);
        run_one(0, -128, 1, "rndm128", y, yc, s, y2, s2);
        check_output("rndm128_y", y2, -32);

        // Backpressure: result must hold and coefficient writes must be ignored.
        load_h(1, 2, 3, 4);
        @(negedge clock);
        out_ready = 1'b0;
        apply_stimulus(1, 9, 1);
        wait_valid(lat);
        check_output("bp_latency", lat, 6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_output($sformatf("bp%0d_valid", i), out_valid, 1);
            check_output($sformatf("bp%0d_y", i), y_out, 9);
            check_output($sformatf("bp%0d_ch", i), out_ch, 1);
            check_output($sformatf("bp%0d_in_ready", i), in_ready, 0);
            check_output($sformatf("bp%0d_coef_ready", i), coef_ready, 0);
            coef_we   = (i == 0);
            coef_addr = 2'd0;
            coef_data = 8'sd50;
        end
        @(negedge clock);
        coef_we   = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check_output("bp_release_valid", out_valid, 0);
        check_output("bp_hold_y", y_out, 9);
        run_one(0, 10, 1, "bp_readback", y, yc, s, y2, s2);
        check_output("bp_readback_y", y, 10);

        // Coefficient write in the same cycle as an accept uses the new value.
        @(negedge clock);
        in_valid = 1'b1; in_valid2 = 1'b1; in_ch = 1'b0; in_ch2 = 2'd0; x_in = 8'sd10;
        flush = 1'b1; coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd5;
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_valid2 = 1'b0; flush = 1'b0; coef_we = 1'b0;
        wait_valid(lat);
        check_output("wr_accept_latency", lat, 6);
        check_output("wr_accept_y", y_out, 50);
        @(posedge clock);
        #1;

        // Reset in the middle of the MAC loop.
        apply_stimulus(0, 7, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_output("mid_reset_valid", out_valid, 0);
        check_output("mid_reset_in_ready", in_ready, 1);
        check_output("mid_reset_coef_ready", coef_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check_output("mid_reset_no_output", seen, 0);
        run_one(1, 10, 0, "coef_cleared", y, yc, s, y2, s2);
        check_output("coef_cleared_y", y, 0);
        load_h(1, 2, 3, 4);
        run_one(0, 10, 0, "line_cleared", y, yc, s, y2, s2);
        check_output("line_cleared_y", y, 10);
        check_output("line_cleared_y2", y2, 3);

        // Out-of-range channel on the 3-channel instance.
        @(negedge clock);
        in_valid2 = 1'b1; in_ch2 = 2'd3; x_in = 8'sd55;
        @(posedge clock);
        #1;
        in_valid2 = 1'b0;
        check_output("ch_err_pulse", ch_err2, 1);
        check_output("ch_err_in_ready", in_ready2, 1);
        @(posedge clock);
        #1;
        check_output("ch_err_single", ch_err2, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid2) seen++;
        end
        check_output("ch_err_no_output", seen, 0);
        run_one(0, 0, 0, "after_err", y, yc, s, y2, s2);
        check_output("after_err_y", y, 20);
        check_output("after_err_y2", y2, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
